// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory slave on the CPU memory bus.
// Captures a request on a four-phase req/ack handshake, waits a fixed
// number of cycles, performs one memory access, then holds ack until the
// CPU drops req. Read data is driven onto the shared DATA_BUS only while
// the response is being presented; the bus is released otherwise.
module mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr_bus,
  inout  wire  [DATA_W-1:0] DATA_BUS,
  input  logic              req,
  input  logic              we,
  output logic              ack,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_STATES);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  logic [1:0]        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              ack_reg, ack_next;
  logic [ADDR_W-1:0] addr_reg;
  logic              we_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              drive_en;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  // Next-state, wait counter and ack sequencing.
  // RESP spends its first cycle with ack low and raises ack on the next
  // edge; from then on ack only falls when req is seen low. This makes ack
  // appear WAIT_STATES+2 edges after capture and guarantees a one-cycle
  // ack pulse even if the CPU has already dropped req.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ack_next   = ack_reg;
    case (state_reg)
      ST_IDLE: begin
        if (req) begin
          if (WAIT_STATES > 0) begin
            cnt_next   = WAIT_LOAD;
            state_next = ST_WAIT;
          end else begin
            state_next = ST_ACCESS;
          end
        end
      end
      ST_WAIT: begin
        cnt_next = cnt_reg - {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_reg == {{(CNT_W-1){1'b0}}, 1'b1}) begin
          state_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        state_next = ST_RESP;
      end
      ST_RESP: begin
        if (!ack_reg) begin
          ack_next = 1'b1;
        end else if (!req) begin
          ack_next   = 1'b0;
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
        ack_next   = 1'b0;
      end
    endcase
  end

  // Control state registers; reset returns to IDLE with ack low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      ack_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ack_reg   <= ack_next;
    end
  end

  // Request capture: address, direction and write data are frozen at the
  // capturing edge so later bus activity cannot disturb the transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_reg  <= '0;
      we_reg    <= 1'b0;
      wdata_reg <= '0;
    end else if (state_reg == ST_IDLE && req) begin
      addr_reg <= addr_bus;
      we_reg   <= we;
      if (we) begin
        wdata_reg <= DATA_BUS;
      end
    end
  end

  // Memory array with registered read; contents survive reset, and an
  // access coinciding with reset is suppressed so no write is committed.
  always_ff @(posedge clk) begin
    if (!reset && state_reg == ST_ACCESS) begin
      if (we_reg) begin
        mem[addr_reg] <= wdata_reg;
      end else begin
        rdata_reg <= mem[addr_reg];
      end
    end
  end

  assign drive_en = (state_reg == ST_RESP) && !we_reg;
  assign DATA_BUS = drive_en ? rdata_reg : {DATA_W{1'bz}};
  assign ack      = ack_reg;
  assign busy     = (state_reg != ST_IDLE);

endmodule
